// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 data-memory load/store unit.
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD,
    SZ_NONE
  } acc_size_t;

  // Access size for a load/store funct3; SZ_NONE marks an illegal encoding.
  // Unsigned variants exist only for loads.
  function automatic acc_size_t access_size(input logic we, input logic [2:0] f3);
    acc_size_t sz;
    sz = SZ_NONE;
    case (f3)
      F3_B:  sz = SZ_BYTE;
      F3_H:  sz = SZ_HALF;
      F3_W:  sz = SZ_WORD;
      F3_BU: sz = we ? SZ_NONE : SZ_BYTE;
      F3_HU: sz = we ? SZ_NONE : SZ_HALF;
      default: sz = SZ_NONE;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational data path: load sign/zero extension and sub-word store merge.
module lsu_data_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_data_o
);

  // Extend the addressed low bytes of the memory word into a register value.
  always_comb begin
    load_data_o = rdata_i;
    case (funct3_i)
      F3_B:  load_data_o = {{24{rdata_i[7]}}, rdata_i[7:0]};
      F3_BU: load_data_o = {24'h0, rdata_i[7:0]};
      F3_H:  load_data_o = {{16{rdata_i[15]}}, rdata_i[15:0]};
      F3_HU: load_data_o = {16'h0, rdata_i[15:0]};
      default: load_data_o = rdata_i;
    endcase
  end

  // Replace the low byte/halfword of the old word, leaving upper bytes intact.
  always_comb begin
    store_data_o = wdata_i;
    case (funct3_i)
      F3_B:    store_data_o = {old_word_i[31:8], wdata_i[7:0]};
      F3_H:    store_data_o = {old_word_i[31:16], wdata_i[15:0]};
      default: store_data_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator between the core execute stage and a word-wide,
// combinationally-read data memory. Sub-word stores use read-modify-write.
// Handshake: a request transfers on the posedge where req_valid && req_ready;
// req_ready is high only in IDLE, and resp_valid is a one-cycle pulse with
// resp_rdata/resp_err held until the next response.
module dmem_lsu
  import rv32_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES        = 256,
  parameter bit          ALLOW_MISALIGNED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output lsu_state_t  dbg_state
);

  lsu_state_t  state_q, state_d;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] mem_addr_q;
  logic [31:0] rdata_q;
  logic        err_q;

  acc_size_t   req_size;
  logic [32:0] req_last_byte;
  logic        req_misal;
  logic        req_oor;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] store_data;

  lsu_data_align u_align (
    .funct3_i     (f3_q),
    .rdata_i      (mem_rdata),
    .old_word_i   (merge_q),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_data_o (store_data)
  );

  // Classify the incoming request; the memory always touches 4 bytes, so
  // the last byte addr+3 must be in range regardless of access size.
  always_comb begin
    req_size      = access_size(req_we, req_funct3);
    req_last_byte = {1'b0, req_addr} + 33'd3;
    req_misal     = !ALLOW_MISALIGNED &&
                    ((req_size == SZ_HALF && req_addr[0]) ||
                     (req_size == SZ_WORD && req_addr[1:0] != 2'b00));
    req_oor       = req_last_byte >= 33'(MEM_BYTES);
    req_err       = (req_size == SZ_NONE) || req_misal || req_oor;
  end

  // Next-state and memory-port outputs; writes only in WRITE/RMW_WR.
  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_wdata = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err)                 state_d = S_RESP;
          else if (!req_we)            state_d = S_LOAD;
          else if (req_funct3 == F3_W) state_d = S_WRITE;
          else                         state_d = S_RMW_RD;
        end
      end
      S_LOAD:   state_d = S_RESP;
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = wdata_q;
        state_d   = S_RESP;
      end
      S_RMW_RD: state_d = S_RMW_WR;
      S_RMW_WR: begin
        mem_we    = 1'b1;
        mem_wdata = store_data;
        state_d   = S_RESP;
      end
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register plus request latch, merge word and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      f3_q       <= 3'b000;
      wdata_q    <= 32'h0;
      merge_q    <= 32'h0;
      mem_addr_q <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            f3_q    <= req_funct3;
            wdata_q <= req_wdata;
            if (req_err) begin
              err_q   <= 1'b1;
              rdata_q <= 32'h0;
            end else begin
              mem_addr_q <= req_addr;
            end
          end
        end
        S_LOAD: begin
          rdata_q <= load_data;
          err_q   <= 1'b0;
        end
        S_RMW_RD: merge_q <= mem_rdata;
        S_WRITE, S_RMW_WR: begin
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = mem_addr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a byte-array memory model.
module tb_dmem_lsu;
  import rv32_mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  lsu_state_t  dbg_state;

  int vectors;
  int miscompares;

  logic [7:0]  mem [256];
  int          we_cnt;
  int          we_viol;
  logic        prev_we;
  logic [31:0] last_waddr;
  logic [31:0] last_wdata;
  int          acc_cnt;
  int          resp_cnt;
  int          resp_viol;
  logic        prev_resp;

  dmem_lsu #(.MEM_BYTES(256), .ALLOW_MISALIGNED(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational memory read, little-endian, out-of-range bytes read 0
  always_comb begin
    mem_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if ({1'b0, mem_addr} + 33'(i) < 33'd256)
        mem_rdata[8*i +: 8] = mem[mem_addr[7:0] + 8'(i)];
    end
  end

  // Memory write port and protocol monitors
  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if ({1'b0, mem_addr} + 33'(i) < 33'd256)
          mem[mem_addr[7:0] + 8'(i)] <= mem_wdata[8*i +: 8];
      we_cnt     <= we_cnt + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
      if (prev_we) we_viol <= we_viol + 1;
    end
    prev_we <= mem_we;
    if (!rst && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    if (resp_valid) begin
      resp_cnt <= resp_cnt + 1;
      if (prev_resp) resp_viol <= resp_viol + 1;
    end
    prev_resp <= resp_valid;
  end

  function automatic logic [31:0] peek_word(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  task automatic poke_word(input logic [7:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a + 8'(i)] = w[8*i +: 8];
  endtask

  // Driver: issue one request from IDLE, measure accept-to-response latency
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd,
                        output logic e, output int wr);
    int  w0;
    bit  done;
    w0 = we_cnt;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
      if (resp_valid) done = 1'b1;
    end
    rd = resp_rdata;
    e  = resp_err;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL resp_pulse: resp_valid=%b req_ready=%b required 0/1", resp_valid, req_ready);
    end
    wr = we_cnt - w0;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_funct3 = 3'b000;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    we_cnt = 0; we_viol = 0; prev_we = 1'b0;
    acc_cnt = 0; resp_cnt = 0; resp_viol = 0; prev_resp = 1'b0;
    last_waddr = 32'h0; last_wdata = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #23;
    vectors++;
    if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_ctl: ready/valid/err/we=%b required 1000",
               {req_ready, resp_valid, resp_err, mem_we});
    end
    vectors++;
    if (resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required all 0",
               resp_rdata, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sw_lw;
    int lat; logic [31:0] rd; logic e; int wr;
    do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, lat, rd, e, wr);
    vectors++;
    if (lat != 2 || e !== 1'b0 || rd !== 32'h0 || wr != 1) begin
      miscompares++;
      $display("FAIL sw_resp: lat=%0d err=%b rdata=%h writes=%0d required 2/0/0/1", lat, e, rd, wr);
    end
    vectors++;
    if (last_waddr !== 32'h10 || last_wdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL sw_write: addr=%h data=%h required 10/deadbeef", last_waddr, last_wdata);
    end
    do_req(1'b0, F3_W, 32'h10, 32'h0, lat, rd, e, wr);
    vectors++;
    if (lat != 2 || e !== 1'b0 || rd !== 32'hDEADBEEF || wr != 0) begin
      miscompares++;
      $display("FAIL lw_resp: lat=%0d err=%b rdata=%h writes=%0d required 2/0/deadbeef/0", lat, e, rd, wr);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3_t [6] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W, F3_W};
    logic [31:0] a_t  [6] = '{32'h20, 32'h20, 32'h22, 32'h22, 32'h20, 32'hFC};
    logic [31:0] e_t  [6] = '{32'hFFFFFFEF, 32'h000000EF, 32'hFFFFDEAD,
                              32'h0000DEAD, 32'hDEADBEEF, 32'h80706050};
    int lat; logic [31:0] rd; logic e; int wr;
    mem[8'h20] = 8'hEF; mem[8'h21] = 8'hBE; mem[8'h22] = 8'hAD; mem[8'h23] = 8'hDE;
    poke_word(8'hFC, 32'h80706050);
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, f3_t[i], a_t[i], 32'h0, lat, rd, e, wr);
      vectors++;
      if (lat != 2 || e !== 1'b0 || rd !== e_t[i] || wr != 0) begin
        miscompares++;
        $display("FAIL load_%0d: lat=%0d err=%b rdata=%h writes=%0d required 2/0/%h/0",
                 i, lat, e, rd, wr, e_t[i]);
      end
    end
  endtask

  task automatic test_rmw;
    int lat; logic [31:0] rd; logic e; int wr;
    poke_word(8'h30, 32'h11223344);
    do_req(1'b1, F3_B, 32'h30, 32'hAAAAAA55, lat, rd, e, wr);
    vectors++;
    if (lat != 3 || e !== 1'b0 || wr != 1 || last_wdata !== 32'h11223355) begin
      miscompares++;
      $display("FAIL sb_rmw: lat=%0d err=%b writes=%0d wdata=%h required 3/0/1/11223355",
               lat, e, wr, last_wdata);
    end
    do_req(1'b0, F3_W, 32'h30, 32'h0, lat, rd, e, wr);
    vectors++;
    if (rd !== 32'h11223355) begin
      miscompares++;
      $display("FAIL sb_readback: rdata=%h required 11223355", rd);
    end
    do_req(1'b1, F3_H, 32'h32, 32'h1234BEEF, lat, rd, e, wr);
    vectors++;
    if (lat != 3 || wr != 1 || last_waddr !== 32'h32 || peek_word(8'h30) !== 32'hBEEF3355) begin
      miscompares++;
      $display("FAIL sh_rmw: lat=%0d writes=%0d addr=%h word=%h required 3/1/32/beef3355",
               lat, wr, last_waddr, peek_word(8'h30));
    end
  endtask

  task automatic test_errors;
    logic        we_t [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3_t [6] = '{F3_W, F3_W, 3'b011, 3'b100, F3_H, F3_B};
    logic [31:0] a_t  [6] = '{32'h31, 32'hFD, 32'h40, 32'h40, 32'h21, 32'hFF};
    int lat; logic [31:0] rd; logic e; int wr;
    for (int i = 0; i < 6; i++) begin
      do_req(we_t[i], f3_t[i], a_t[i], 32'hCAFEF00D, lat, rd, e, wr);
      vectors++;
      if (lat != 1 || e !== 1'b1 || rd !== 32'h0 || wr != 0) begin
        miscompares++;
        $display("FAIL err_%0d: lat=%0d err=%b rdata=%h writes=%0d required 1/1/0/0",
                 i, lat, e, rd, wr);
      end
    end
  endtask

  task automatic test_reset_in_rmw;
    int r0;
    int w0;
    poke_word(8'h40, 32'h01020304);
    r0 = resp_cnt;
    w0 = we_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B;
    req_addr = 32'h40; req_wdata = 32'h000000FF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    vectors++;
    if (mem_we !== 1'b1) begin
      miscompares++;
      $display("FAIL rmw_wr_entry: mem_we=%b required 1", mem_we);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL async_we_drop: mem_we=%b required 0", mem_we);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || resp_cnt != r0 || we_cnt != w0 || peek_word(8'h40) !== 32'h01020304) begin
      miscompares++;
      $display("FAIL reset_rmw: ready=%b resps=%0d writes=%0d word=%h required 1/0/0/01020304",
               req_ready, resp_cnt - r0, we_cnt - w0, peek_word(8'h40));
    end
  endtask

  task automatic test_back_to_back;
    int a0, r0, bound;
    logic [31:0] d;
    a0 = acc_cnt;
    r0 = resp_cnt;
    d  = 32'h0;
    for (int i = 0; i < 20; i++) begin
      bound = 0;
      @(negedge clk);
      while (!req_ready && bound < 10) begin
        @(negedge clk);
        bound++;
      end
      if (i % 2 == 0) d = {8'(i), 8'hC3, 16'(i * 37 + 5)};
      req_valid  = 1'b1;
      req_we     = (i % 2 == 0);
      req_funct3 = F3_W;
      req_addr   = 32'h80 + 32'(4 * (i / 2));
      req_wdata  = (i % 2 == 0) ? d : 32'h0BADBAD0;
      @(posedge clk); #1;
      bound = 0;
      @(negedge clk);
      while (!resp_valid && bound < 10) begin
        @(negedge clk);
        bound++;
      end
      if (i % 2 == 1) begin
        vectors++;
        if (resp_rdata !== d || resp_err !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_lw_%0d: rdata=%h err=%b required %h/0", i, resp_rdata, resp_err, d);
        end
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (acc_cnt - a0 != 20 || resp_cnt - r0 != 20) begin
      miscompares++;
      $display("FAIL b2b_counts: accepts=%0d responses=%0d required 20/20", acc_cnt - a0, resp_cnt - r0);
    end
  endtask

  task automatic test_protocol;
    vectors++;
    if (we_viol != 0 || resp_viol != 0) begin
      miscompares++;
      $display("FAIL protocol: consecutive mem_we=%0d consecutive resp_valid=%0d required 0/0",
               we_viol, resp_viol);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_sw_lw();
    test_loads();
    test_rmw();
    test_errors();
    test_reset_in_rmw();
    test_back_to_back();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store initiator that sits between the RV32 core's execute stage and the byte-addressed, word-wide data memory port.
- The memory port reads combinationally: 4 bytes at Addr..Addr+3, little-endian, byte Addr in bits [7:0]. It writes all 4 bytes on posedge when the write flag is 1.
- This block converts core load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into memory cycles. Sub-word stores use read-modify-write.
- It performs sign/zero extension and flags illegal, misaligned or out-of-range accesses.

Parameters:
- MEM_BYTES, 256, size of data memory in bytes; any access touching byte >= MEM_BYTES is an error.
- ALLOW_MISALIGNED, 0, 1 lets halfword/word accesses at any byte offset; 0 flags them as errors.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  core request present.
- req_ready  out  1  high only in IDLE; transfer on req_valid&&req_ready.
- req_we  in  1  0 load, 1 store.
- req_funct3  in  3  RV32 funct3 (size/sign).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (low bits used for SB/SH).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; illegal funct3, misaligned, or out of range.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_we  out  1  memory write flag, 0 read / 1 write.
- mem_rdata  in  32  memory read data, combinational from mem_addr.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE.
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
- Accept: in IDLE, on req_valid at posedge, latch we/funct3/addr/wdata and classify.
  - Error if any of:
    - load funct3 in {011,110,111};
    - store funct3 > 010;
    - !ALLOW_MISALIGNED and (half with addr[0]=1, or word with addr[1:0]!=0);
    - addr+3 >= MEM_BYTES (computed 33-bit, no wrap).
  - Note: the memory always touches 4 bytes, so every access needs addr+3 in range.
- States: IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP.
  - IDLE -> RESP if error (no memory cycle, mem_we stays 0).
  - IDLE -> LOAD for a legal load.
  - IDLE -> WRITE for SW.
  - IDLE -> RMW_RD for SB/SH.
  - LOAD: mem_addr=addr, mem_we=0; capture extended mem_rdata at posedge -> RESP.
    - LB: sext [7:0]. LBU: zext [7:0].
    - LH: sext [15:0]. LHU: zext [15:0].
    - LW: [31:0].
  - WRITE: mem_addr=addr, mem_wdata=wdata, mem_we=1 -> RESP.
  - RMW_RD: mem_addr=addr, mem_we=0; capture mem_rdata into merge register -> RMW_WR.
  - RMW_WR: mem_we=1, mem_wdata = captured word with [7:0] (SB) or [15:0] (SH) replaced by wdata low bits; upper bytes unchanged -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, req_ready=0 -> IDLE.
- Latency from accept edge to resp_valid:
  - error: 1 cycle.
  - load / SW: 2 cycles.
  - SB/SH: 3 cycles.
- Throughput: no back-to-back overlap; a new request is accepted no earlier than the cycle after RESP.
- Outputs outside active states: mem_we=0, mem_wdata=0, mem_addr holds last value.
- resp_rdata/resp_err are registered, valid only while resp_valid=1, and held until the next response.
- Inputs are ignored outside IDLE; req_* may change freely once accepted.
- Reset during WRITE/RMW_WR: mem_we drops asynchronously; no write occurs at a posedge while rst=1. A pending response is discarded.
- mem_we is never 1 in two consecutive cycles.

Decomposition:
- Shared package rv32_mem_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - the lsu_state_t enum (6 states);
  - the access-size decode function.
- One combinational sub-module, lsu_data_align:
  - load extend: funct3, rdata -> result;
  - store merge: funct3, old word, wdata -> new word.
- The FSM and registers stay in dmem_lsu.

Test Plan:
- SW addr=0x10, wdata=0xDEADBEEF, then LW 0x10 -> one write cycle at 0x10; load resp_rdata=0xDEADBEEF, resp_err=0, response 2 cycles after accept.
- Memory 0x20..0x23 = EF BE AD DE; LB 0x20 -> 0xFFFFFFEF; LBU 0x20 -> 0x000000EF; LH 0x22 -> 0xFFFFDEAD; LHU 0x22 -> 0x0000DEAD.
- Memory 0x30 word = 0x11223344; SB addr=0x30, wdata=0xAAAAAA55 -> RMW_RD then RMW_WR with mem_wdata=0x11223355; LW 0x30 -> 0x11223355; response 3 cycles after accept.
- Error cases, each giving resp_err=1 after 1 cycle, mem_we never asserted, resp_rdata=0:
  - LW 0x31 with ALLOW_MISALIGNED=0;
  - LW 0xFD with MEM_BYTES=256;
  - load funct3=011.
- Assert rst asynchronously mid-cycle during RMW_WR -> mem_we falls without waiting for clk; target word unchanged on readback; req_ready=1 after release; no resp_valid.
- Hold req_valid high with alternating SW/LW for 20 requests -> exactly one accept per transaction, no accept while req_ready=0, resp_valid is a single-cycle pulse per request.
